pupil_row_sequencer: RTL and testbench

Sequencer between the Stonyman pixel capture path and `pupil_detect`. It accepts pixels one at a time with a ready/valid handshake and assembles each image row in a fill buffer. Completed rows are presented to `pupil_detect` on `img_buf_newline`, and each row is held for a fixed processing window. The block also drives `frame_capture_done`, so `pupil_detect` sees the frame boundaries it expects.

---
 rtl/pupil_row_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_pupil_row_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pupil_row_sequencer.sv
// Row assembly and hand-off sequencer feeding pupil_detect, one row per processing window.
// Optional running row-minimum statistics are built when PUPIL_SEQ_ROWSTAT_EN is defined.
module pupil_row_sequencer #(
    parameter int RESOLUTION  = 112,
    parameter int ROWS        = 112,
    parameter int PROC_CYCLES = 113
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    frame_start,
    input  logic                    pix_valid,
    input  logic [7:0]              pix_data,
    output logic                    pix_ready,
    output logic [RESOLUTION*8-1:0] img_buf_newline,
    output logic                    row_strobe,
    output logic                    frame_capture_done,
    output logic [7:0]              row_count,
    output logic                    busy,
    output logic [7:0]              row_min,
    output logic [7:0]              row_min_col
);

    localparam int COL_W = (RESOLUTION > 1) ? $clog2(RESOLUTION) : 1;
    localparam int RF_W  = $clog2(ROWS + 1);
    localparam int WIN_W = $clog2(PROC_CYCLES);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(RESOLUTION - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(PROC_CYCLES - 1);
    localparam logic [RF_W-1:0]  RF_MAX   = RF_W'(ROWS);
    localparam logic [7:0]       ROWS_8   = 8'(ROWS);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                    state_q, state_d;
    logic [COL_W-1:0]          col_q, col_d;
    logic                      fill_full_q, fill_full_d;
    logic [RF_W-1:0]           rows_filled_q, rows_filled_d;
    logic [7:0]                row_count_q, row_count_d;
    logic                      strobe_q, strobe_d;
    logic                      win_active_q, win_active_d;
    logic [WIN_W-1:0]          win_cnt_q, win_cnt_d;
    logic [RESOLUTION*8-1:0]   fill_q, fill_d;
    logic [RESOLUTION*8-1:0]   img_q, img_d;

    logic start;
    logic accept;
    logic win_expire;
    logic transfer;
    logic frame_end;

    assign start      = (state_q == IDLE) && frame_start;
    assign accept     = pix_valid && pix_ready;
    assign win_expire = win_active_q && (win_cnt_q == WIN_LAST);
    assign transfer   = fill_full_q && (!win_active_q || win_expire);
    // The frame ends only once the last row's window has fully elapsed.
    assign frame_end  = win_expire && !transfer && (row_count_q == ROWS_8);

    // ---------------- frame FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- frame FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_start) state_d = RUN;
            RUN:     if (frame_end)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- frame FSM: outputs ----------------
    always_comb begin
        busy               = (state_q == RUN);
        frame_capture_done = (state_q == IDLE);
        pix_ready          = (state_q == RUN) && !fill_full_q && (rows_filled_q < RF_MAX);
    end

    // Each fill slot captures the pixel when the column pointer addresses it.
    for (genvar gi = 0; gi < RESOLUTION; gi++) begin : g_fill
        assign fill_d[gi*8 +: 8] = (accept && (col_q == COL_W'(gi))) ? pix_data
                                                                     : fill_q[gi*8 +: 8];
    end

    always_comb begin
        col_d         = col_q;
        fill_full_d   = fill_full_q;
        rows_filled_d = rows_filled_q;
        row_count_d   = row_count_q;
        strobe_d      = 1'b0;
        win_active_d  = win_active_q;
        win_cnt_d     = win_cnt_q;
        img_d         = img_q;
        if (start) begin
            col_d         = '0;
            fill_full_d   = 1'b0;
            rows_filled_d = '0;
            row_count_d   = '0;
            win_active_d  = 1'b0;
            win_cnt_d     = '0;
        end else begin
            if (accept) begin
                if (col_q == COL_LAST) begin
                    col_d         = '0;
                    fill_full_d   = 1'b1;
                    rows_filled_d = rows_filled_q + RF_W'(1);
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            // A pending row takes priority over window expiry, so windows abut.
            if (transfer) begin
                img_d        = fill_q;
                fill_full_d  = 1'b0;
                row_count_d  = row_count_q + 8'd1;
                strobe_d     = 1'b1;
                win_active_d = 1'b1;
                win_cnt_d    = '0;
            end else if (win_active_q) begin
                if (win_expire) begin
                    win_active_d = 1'b0;
                end else begin
                    win_cnt_d = win_cnt_q + WIN_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            col_q         <= '0;
            fill_full_q   <= 1'b0;
            rows_filled_q <= '0;
            row_count_q   <= '0;
            strobe_q      <= 1'b0;
            win_active_q  <= 1'b0;
            win_cnt_q     <= '0;
            fill_q        <= '0;
            img_q         <= '0;
        end else begin
            col_q         <= col_d;
            fill_full_q   <= fill_full_d;
            rows_filled_q <= rows_filled_d;
            row_count_q   <= row_count_d;
            strobe_q      <= strobe_d;
            win_active_q  <= win_active_d;
            win_cnt_q     <= win_cnt_d;
            fill_q        <= fill_d;
            img_q         <= img_d;
        end
    end

    assign img_buf_newline = img_q;
    assign row_strobe      = strobe_q;
    assign row_count       = row_count_q;

`ifdef PUPIL_SEQ_ROWSTAT_EN
    logic [7:0]       run_min_q, run_min_d;
    logic [COL_W-1:0] run_min_col_q, run_min_col_d;
    logic [7:0]       row_min_q, row_min_d;
    logic [COL_W-1:0] row_min_col_q, row_min_col_d;

    // Strict less-than keeps the earliest column on ties.
    always_comb begin
        run_min_d     = run_min_q;
        run_min_col_d = run_min_col_q;
        row_min_d     = row_min_q;
        row_min_col_d = row_min_col_q;
        if (accept && ((col_q == '0) || (pix_data < run_min_q))) begin
            run_min_d     = pix_data;
            run_min_col_d = col_q;
        end
        if (transfer) begin
            row_min_d     = run_min_q;
            row_min_col_d = run_min_col_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            run_min_q     <= '0;
            run_min_col_q <= '0;
            row_min_q     <= '0;
            row_min_col_q <= '0;
        end else begin
            run_min_q     <= run_min_d;
            run_min_col_q <= run_min_col_d;
            row_min_q     <= row_min_d;
            row_min_col_q <= row_min_col_d;
        end
    end

    assign row_min     = row_min_q;
    assign row_min_col = 8'(row_min_col_q);
`else
    assign row_min     = 8'd0;
    assign row_min_col = 8'd0;
`endif

endmodule

// File: tb/tb_pupil_row_sequencer.sv
// Directed bench for pupil_row_sequencer with RESOLUTION=4, ROWS=3, PROC_CYCLES=6.
// Expected row minimum values depend on PUPIL_SEQ_ROWSTAT_EN.
module tb_pupil_row_sequencer;

    localparam int RESOLUTION  = 4;
    localparam int ROWS        = 3;
    localparam int PROC_CYCLES = 6;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    frame_start;
    logic                    pix_valid;
    logic [7:0]              pix_data;
    logic                    pix_ready;
    logic [RESOLUTION*8-1:0] img_buf_newline;
    logic                    row_strobe;
    logic                    frame_capture_done;
    logic [7:0]              row_count;
    logic                    busy;
    logic [7:0]              row_min;
    logic [7:0]              row_min_col;

    int checks = 0;
    int errors = 0;
    int feed_idx = 0;
    logic [7:0] feed [0:23];

`ifdef PUPIL_SEQ_ROWSTAT_EN
    localparam logic [7:0] EXP_MIN     = 8'h08;
    localparam logic [7:0] EXP_MIN_COL = 8'd1;
`else
    localparam logic [7:0] EXP_MIN     = 8'h00;
    localparam logic [7:0] EXP_MIN_COL = 8'd0;
`endif

    pupil_row_sequencer #(
        .RESOLUTION (RESOLUTION),
        .ROWS       (ROWS),
        .PROC_CYCLES(PROC_CYCLES)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .frame_start       (frame_start),
        .pix_valid         (pix_valid),
        .pix_data          (pix_data),
        .pix_ready         (pix_ready),
        .img_buf_newline   (img_buf_newline),
        .row_strobe        (row_strobe),
        .frame_capture_done(frame_capture_done),
        .row_count         (row_count),
        .busy              (busy),
        .row_min           (row_min),
        .row_min_col       (row_min_col)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; the feeder moves to the next pixel whenever the
    // handshake completed on that edge.
    task automatic step();
        logic acc;
        acc = pix_valid && pix_ready;
        @(posedge clock);
        #1;
        if (acc) begin
            feed_idx++;
            pix_data = feed[feed_idx];
        end
        if (row_strobe === 1'b1)
            $display("row %0d presented: %h", row_count, img_buf_newline);
    endtask

    initial begin
        feed[0]  = 8'h10; feed[1]  = 8'h20; feed[2]  = 8'h30; feed[3]  = 8'h40;
        feed[4]  = 8'h11; feed[5]  = 8'h22; feed[6]  = 8'h33; feed[7]  = 8'h44;
        feed[8]  = 8'h55; feed[9]  = 8'h66; feed[10] = 8'h77; feed[11] = 8'h88;
        feed[12] = 8'h50; feed[13] = 8'h08; feed[14] = 8'h08; feed[15] = 8'h90;
        feed[16] = 8'hB1; feed[17] = 8'hB2;
        feed[18] = 8'hA1; feed[19] = 8'hA2; feed[20] = 8'hA3; feed[21] = 8'hA4;
        feed[22] = 8'h00; feed[23] = 8'h00;

        // Reset held with valid and frame_start asserted
        reset       = 1'b0;
        frame_start = 1'b1;
        pix_valid   = 1'b1;
        pix_data    = feed[0];
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_ready", pix_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", frame_capture_done, 1);
            chk("rst_strobe", row_strobe, 0);
            chk("rst_rowcnt", row_count, 0);
            chk("rst_img", img_buf_newline, 0);
            chk("rst_min", row_min, 0);
            chk("rst_mincol", row_min_col, 0);
        end
        chk("rst_no_accept", feed_idx, 0);

        reset       = 1'b1;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        step();
        chk("idle_busy", busy, 0);
        chk("idle_done", frame_capture_done, 1);

        // Frame 1, row 1
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("start_ready", pix_ready, 1);
        chk("start_busy", busy, 1);
        chk("start_done", frame_capture_done, 0);
        chk("start_rowcnt", row_count, 0);
        pix_valid = 1'b1;
        pix_data  = feed[0];
        for (int i = 0; i < 4; i++) step();
        chk("row1_accepted", feed_idx, 4);
        chk("row1_full_ready", pix_ready, 0);
        chk("row1_pre_strobe", row_strobe, 0);
        step();
        chk("row1_strobe", row_strobe, 1);
        chk("row1_img", img_buf_newline, 32'h40302010);
        chk("row1_rowcnt", row_count, 1);
        chk("row1_done", frame_capture_done, 0);

        // Rows 2 and 3 under continuous valid: strobes 6 cycles apart
        for (int n = 1; n <= 6; n++) begin
            step();
            if (n < 6) chk("row2_strobe_gap", row_strobe, 0);
            if (n == 4) chk("row2_accepted", feed_idx, 8);
            if (n == 4 || n == 5) chk("row2_wait_ready", pix_ready, 0);
        end
        chk("row2_strobe", row_strobe, 1);
        chk("row2_img", img_buf_newline, 32'h44332211);
        chk("row2_rowcnt", row_count, 2);
        for (int n = 1; n <= 6; n++) begin
            step();
            if (n < 6) chk("row3_strobe_gap", row_strobe, 0);
        end
        chk("row3_strobe", row_strobe, 1);
        chk("row3_img", img_buf_newline, 32'h88776655);
        chk("row3_rowcnt", row_count, 3);
        chk("row3_done", frame_capture_done, 0);

        // Frame end: done rises 6 cycles after row-3 strobe
        for (int n = 1; n <= 6; n++) begin
            step();
            if (n < 6) chk("end_done_low", frame_capture_done, 0);
            chk("end_ready_low", pix_ready, 0);
        end
        chk("end_done", frame_capture_done, 1);
        chk("end_busy", busy, 0);
        for (int n = 0; n < 3; n++) step();
        chk("end_ready", pix_ready, 0);
        chk("end_no_accept", feed_idx, 12);
        chk("end_img_hold", img_buf_newline, 32'h88776655);
        chk("end_rowcnt_hold", row_count, 3);

        // Frame 2: row statistics, ignored frame_start, then reset mid-row
        pix_valid = 1'b0;
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("f2_rowcnt_clear", row_count, 0);
        pix_valid = 1'b1;
        pix_data  = feed[12];
        for (int i = 0; i < 5; i++) step();
        chk("f2_strobe", row_strobe, 1);
        chk("f2_img", img_buf_newline, 32'h90080850);
        chk("f2_rowcnt", row_count, 1);
        chk("stat_min", row_min, EXP_MIN);
        chk("stat_mincol", row_min_col, EXP_MIN_COL);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("ign_rowcnt", row_count, 1);
        chk("ign_busy", busy, 1);
        chk("ign_strobe", row_strobe, 0);
        step();
        chk("abort_partial", feed_idx, 18);
        reset = 1'b0;
        step();
        chk("abort_img", img_buf_newline, 0);
        chk("abort_rowcnt", row_count, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", frame_capture_done, 1);
        chk("abort_ready", pix_ready, 0);
        chk("abort_min", row_min, 0);
        reset     = 1'b1;
        pix_valid = 1'b0;
        feed_idx  = 18;
        pix_data  = feed[18];
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        pix_valid   = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("f3_strobe", row_strobe, 1);
        chk("f3_img", img_buf_newline, 32'hA4A3A2A1);
        chk("f3_rowcnt", row_count, 1);
        pix_valid = 1'b0;
        step();
        chk("f3_strobe_pulse", row_strobe, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
